// File: rtl/event_frame_fifo_pkg.sv
// Shared definitions for the fiber event path: word widths, the EOF tag
// position inside a FIFO entry, default FIFO geometry and the selector
// type used for the read-side lookahead word.
package event_frame_fifo_pkg;

  // Event word width shared by frame source, FIFO and serializer
  localparam int FIBER_DW = 32;

  // EOF tag sits just above the data word inside a FIFO entry {EOF, DATA}
  localparam int EOF_BIT = FIBER_DW;

  // Default FIFO geometry
  localparam int FIFO_AW          = 9;
  localparam int FIFO_FULL_MARGIN = 4;

  // Where the word currently at the read pointer comes from
  typedef enum logic {
    HEAD_FROM_RAM    = 1'b0,
    HEAD_FROM_BYPASS = 1'b1
  } head_src_e;

endpackage

// File: rtl/event_fifo_ram.sv
// Simple dual-port storage for the event FIFO: one write port, one read
// port with a registered output. No reset on the array so it maps onto
// block RAM; a read of an address written on the same edge returns the
// old contents.
module event_fifo_ram #(
  parameter int AW = 9,
  parameter int WW = 33
) (
  input  logic          CK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  logic [WW-1:0] mem [2**AW];

  // Write port: store one entry per cycle when enabled
  always_ff @(posedge CK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port: always reading, old data on address collision
  always_ff @(posedge CK) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/event_frame_fifo.sv
// Frame-aware FIFO between the frame source and the fiber serializer.
// Stores {EOF, DATA} per entry, tracks stored words and complete frames,
// raises an early FULL for a source with registered write latency, and
// flags (sticky) any word dropped because the FIFO was truly full.
//
// The RAM is read one entry ahead: its read address is the read pointer
// as it will be after this edge, so the word (and its EOF tag) at the
// current read pointer is always on hand. That lets a read present data
// one cycle later and lets the frame counter see the EOF tag of the entry
// being read in the same cycle. A single-entry bypass covers the case
// where the entry the lookahead needs is being written on the same edge.
module event_frame_fifo
  import event_frame_fifo_pkg::*;
#(
  parameter int AW          = FIFO_AW,
  parameter int DW          = FIBER_DW,
  parameter int FULL_MARGIN = FIFO_FULL_MARGIN
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          WR,
  input  logic [DW-1:0] DATA,
  input  logic          EOF,
  output logic          FULL,
  input  logic          RD,
  output logic [DW-1:0] Q,
  output logic          Q_EOF,
  output logic          Q_VALID,
  output logic          EMPTY,
  output logic          FRAME_AVAIL,
  output logic [AW:0]   FRAME_CNT,
  output logic [AW:0]   USEDW,
  output logic          OVERFLOW,
  input  logic          CLR_OVF
);

  localparam int           WW      = DW + 1;
  localparam int           EOF_IDX = (DW == FIBER_DW) ? EOF_BIT : DW;
  localparam logic [AW:0]  DEPTH_V = (AW+1)'(2**AW);
  localparam logic [AW:0]  MARGIN_V = (AW+1)'(FULL_MARGIN);

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   rptr_next;
  logic [AW:0]   usedw_next;
  logic [AW:0]   frame_cnt_next;
  logic [AW:0]   free_next;
  logic          truly_full;
  logic          wr_ok;
  logic          rd_ok;
  logic          frame_inc;
  logic          frame_dec;
  logic          bypass_hit;
  logic [WW-1:0] wr_word;
  logic [WW-1:0] ram_q;
  logic [WW-1:0] byp_word;
  logic [WW-1:0] head_word;
  logic          head_eof;
  head_src_e     head_src;

  // Accept decisions, lookahead address, head word and next counter values
  always_comb begin
    truly_full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    wr_ok      = WR & ~truly_full;
    rd_ok      = RD & ~EMPTY;
    wr_word    = {EOF, DATA};
    rptr_next  = rptr + {{AW{1'b0}}, rd_ok};
    bypass_hit = wr_ok && (wptr == rptr_next);

    head_word  = (head_src == HEAD_FROM_BYPASS) ? byp_word : ram_q;
    head_eof   = head_word[EOF_IDX];

    frame_inc  = wr_ok & EOF;
    frame_dec  = rd_ok & head_eof;

    usedw_next = USEDW;
    case ({wr_ok, rd_ok})
      2'b10:   usedw_next = USEDW + 1'b1;
      2'b01:   usedw_next = USEDW - 1'b1;
      default: usedw_next = USEDW;
    endcase

    frame_cnt_next = FRAME_CNT;
    case ({frame_inc, frame_dec})
      2'b10:   frame_cnt_next = FRAME_CNT + 1'b1;
      2'b01:   frame_cnt_next = FRAME_CNT - 1'b1;
      default: frame_cnt_next = FRAME_CNT;
    endcase

    free_next = DEPTH_V - usedw_next;
  end

  event_fifo_ram #(
    .AW (AW),
    .WW (WW)
  ) u_ram (
    .CK    (CK),
    .we    (wr_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (wr_word),
    .raddr (rptr_next[AW-1:0]),
    .rdata (ram_q)
  );

  // Pointer advance on accepted writes and reads, wrapping naturally
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      rptr <= rptr_next;
    end
  end

  // Capture a word the lookahead needs but the RAM cannot return yet
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      head_src <= HEAD_FROM_RAM;
      byp_word <= '0;
    end else begin
      head_src <= bypass_hit ? HEAD_FROM_BYPASS : HEAD_FROM_RAM;
      if (bypass_hit) byp_word <= wr_word;
    end
  end

  // Word/frame counters and their derived flags, all updated together
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      USEDW       <= '0;
      FRAME_CNT   <= '0;
      EMPTY       <= 1'b1;
      FULL        <= 1'b0;
      FRAME_AVAIL <= 1'b0;
    end else begin
      USEDW       <= usedw_next;
      FRAME_CNT   <= frame_cnt_next;
      EMPTY       <= (usedw_next == '0);
      FULL        <= (free_next <= MARGIN_V);
      FRAME_AVAIL <= (frame_cnt_next != '0);
    end
  end

  // Read data register: loads on an accepted read, holds otherwise
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      Q       <= '0;
      Q_EOF   <= 1'b0;
      Q_VALID <= 1'b0;
    end else begin
      Q_VALID <= rd_ok;
      if (rd_ok) begin
        Q     <= head_word[DW-1:0];
        Q_EOF <= head_eof;
      end
    end
  end

  // Sticky overflow: a write while truly full sets it, and setting beats clearing
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      OVERFLOW <= 1'b0;
    end else if (WR && truly_full) begin
      OVERFLOW <= 1'b1;
    end else if (CLR_OVF) begin
      OVERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_frame_fifo.sv
// Self-checking bench for event_frame_fifo: a queue-based model of the
// FIFO is compared against the DUT on every falling edge, and a few
// hand-computed values pin the model at the interesting points.
module tb_event_frame_fifo;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 512;

  logic          CK = 1'b0;
  logic          RST = 1'b0;
  logic          WR = 1'b0;
  logic [DW-1:0] DATA = '0;
  logic          EOF = 1'b0;
  logic          RD = 1'b0;
  logic          CLR_OVF = 1'b0;
  logic          FULL, Q_EOF, Q_VALID, EMPTY, FRAME_AVAIL, OVERFLOW;
  logic [DW-1:0] Q;
  logic [AW:0]   FRAME_CNT, USEDW;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  event_frame_fifo #(.AW(AW), .DW(DW), .FULL_MARGIN(4)) dut (
    .CK          (CK),
    .RST         (RST),
    .WR          (WR),
    .DATA        (DATA),
    .EOF         (EOF),
    .FULL        (FULL),
    .RD          (RD),
    .Q           (Q),
    .Q_EOF       (Q_EOF),
    .Q_VALID     (Q_VALID),
    .EMPTY       (EMPTY),
    .FRAME_AVAIL (FRAME_AVAIL),
    .FRAME_CNT   (FRAME_CNT),
    .USEDW       (USEDW),
    .OVERFLOW    (OVERFLOW),
    .CLR_OVF     (CLR_OVF)
  );

  always #5 CK = ~CK;

  // Reference model: the stored entries as a plain queue
  logic [DW:0]   mq[$];
  logic [DW-1:0] m_q = '0;
  logic          m_q_eof = 1'b0;
  logic          m_q_valid = 1'b0;
  logic          m_ovf = 1'b0;
  int            m_written = 0;

  function automatic int m_frames();
    int n = 0;
    foreach (mq[i]) if (mq[i][DW]) n++;
    return n;
  endfunction

  // Advance the model by one clock, or clear it on reset
  always @(posedge CK or posedge RST) begin
    if (RST) begin
      mq.delete();
      m_q       = '0;
      m_q_eof   = 1'b0;
      m_q_valid = 1'b0;
      m_ovf     = 1'b0;
    end else begin
      bit          full_now, w_ok, r_ok;
      logic [DW:0] w;
      full_now  = (mq.size() == DEPTH);
      w_ok      = WR && !full_now;
      r_ok      = RD && (mq.size() != 0);
      m_q_valid = r_ok;
      if (r_ok) begin
        w       = mq.pop_front();
        m_q     = w[DW-1:0];
        m_q_eof = w[DW];
      end
      if (w_ok) begin
        mq.push_back({EOF, DATA});
        m_written++;
      end
      if (WR && full_now) m_ovf = 1'b1;
      else if (CLR_OVF)   m_ovf = 1'b0;
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge
  always @(negedge CK) begin
    if (check_en && !RST) begin
      check_output("usedw",       USEDW,       mq.size());
      check_output("frame_cnt",   FRAME_CNT,   m_frames());
      check_output("empty",       EMPTY,       mq.size() == 0);
      check_output("full",        FULL,        (DEPTH - mq.size()) <= 4);
      check_output("frame_avail", FRAME_AVAIL, m_frames() != 0);
      check_output("overflow",    OVERFLOW,    m_ovf);
      check_output("q_valid",     Q_VALID,     m_q_valid);
      check_output("q",           Q,           m_q);
      check_output("q_eof",       Q_EOF,       m_q_eof);
    end
  end

  // Drive one cycle of inputs, then return just after the clock edge
  task automatic apply_stimulus(input bit wr, input logic [DW-1:0] data, input bit eof,
                                input bit rd, input bit clr);
    WR = wr; DATA = data; EOF = eof; RD = rd; CLR_OVF = clr;
    @(posedge CK);
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (!EMPTY && n < 700) begin
      apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    check_output("drain_done", EMPTY, 1'b1);
    idle();
  endtask

  logic [DW-1:0] frame [16];

  initial begin
    // Reset and its output state
    #1 RST = 1'b1;
    #3;
    check_output("rst_usedw", USEDW, 0);
    check_output("rst_empty", EMPTY, 1);
    check_output("rst_full",  FULL, 0);
    @(negedge CK);
    #2 RST = 1'b0;
    @(posedge CK); #1;
    check_en = 1'b1;

    // Read while empty is ignored; single word round trip
    $display("[TB] empty read and single word");
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_output("empty_rd_no_valid", Q_VALID, 0);
    apply_stimulus(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_output("single_q_valid", Q_VALID, 1);
    check_output("single_q", Q, 32'hA5A5_0001);
    idle();
    check_output("single_q_valid_drop", Q_VALID, 0);
    check_output("single_q_hold", Q, 32'hA5A5_0001);

    // One 16-word frame in and out
    $display("[TB] single frame");
    for (int i = 0; i < 16; i++) begin
      frame[i] = $urandom;
      apply_stimulus(1'b1, frame[i], i == 15, 1'b0, 1'b0);
    end
    check_output("frame_usedw", USEDW, 16);
    check_output("frame_cnt_1", FRAME_CNT, 1);
    check_output("frame_avail_1", FRAME_AVAIL, 1);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check_output("frame_rd_q", Q, frame[i]);
      check_output("frame_rd_eof", Q_EOF, i == 15);
    end
    idle();
    check_output("frame_cnt_0", FRAME_CNT, 0);

    // Fill with a source that reacts to FULL two cycles late
    $display("[TB] almost-full back-pressure");
    begin
      bit p0 = 1'b0, p1 = 1'b0;
      int first_full = -1;
      int after = 0;
      for (int n = 0; n < 700 && after < 6; n++) begin
        if (FULL && first_full < 0) first_full = int'(USEDW);
        if (first_full >= 0) after++;
        p1 = p0;
        p0 = FULL;
        apply_stimulus(!p1, $urandom, ($urandom % 16) == 0, 1'b0, 1'b0);
      end
      check_output("full_at_508", first_full, 508);
      check_output("usedw_le_512", USEDW <= 512, 1);
      check_output("no_overflow", OVERFLOW, 0);
    end

    // Overflow on a truly full FIFO, set beats clear, clear alone works
    $display("[TB] overflow");
    for (int n = 0; n < 10 && USEDW != 512; n++)
      apply_stimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    check_output("usedw_512", USEDW, 512);
    apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    check_output("ovf_set", OVERFLOW, 1);
    check_output("ovf_usedw", USEDW, 512);
    apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    check_output("ovf_set_wins", OVERFLOW, 1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_output("ovf_cleared", OVERFLOW, 0);
    drain();

    // Simultaneous EOF write and EOF read, then a long random stream
    $display("[TB] simultaneous frames and wrap");
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
      check_output("simul_frame_cnt", FRAME_CNT, 4);
      check_output("simul_usedw", USEDW, 4);
    end
    begin
      int start = m_written;
      int n = 0;
      while (m_written < start + 3 * DEPTH && n < 8000) begin
        apply_stimulus(($urandom % 100) < 70, $urandom, ($urandom % 8) == 0,
                       ($urandom % 100) < 65, ($urandom % 50) == 0);
        n++;
      end
      check_output("stream_done", m_written >= start + 3 * DEPTH, 1);
    end
    drain();

    // Asynchronous reset in the middle of a frame
    $display("[TB] reset mid-frame");
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    WR = 1'b0; RD = 1'b0;
    #2 RST = 1'b1;
    #1;
    check_output("arst_usedw", USEDW, 0);
    check_output("arst_frame_cnt", FRAME_CNT, 0);
    check_output("arst_empty", EMPTY, 1);
    check_output("arst_full", FULL, 0);
    check_output("arst_q_valid", Q_VALID, 0);
    check_output("arst_q", Q, 0);
    @(negedge CK);
    #2 RST = 1'b0;
    @(posedge CK); #1;
    for (int i = 0; i < 16; i++) begin
      frame[i] = $urandom;
      apply_stimulus(1'b1, frame[i], i == 15, 1'b0, 1'b0);
    end
    check_output("post_rst_cnt", FRAME_CNT, 1);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check_output("post_rst_q", Q, frame[i]);
      check_output("post_rst_eof", Q_EOF, i == 15);
    end
    idle();
    idle();

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
